// File: rtl/bus_pkg.sv
// Shared bus constants: field widths, slave id codes and the 5-bit state encoding
// used by both the UART-to-bus master and its serial slaves.
package bus_pkg;

    localparam int ADDR_W         = 14;
    localparam int DATA_W         = 8;
    localparam int ID_W           = 2;
    localparam int DATA_START_BIT = 6;

    localparam logic [ID_W-1:0] SLAVE_ID_0 = 2'b00;
    localparam logic [ID_W-1:0] SLAVE_ID_1 = 2'b01;
    localparam logic [ID_W-1:0] SLAVE_ID_2 = 2'b10;
    localparam logic [ID_W-1:0] SLAVE_ID_3 = 2'b11;

    localparam logic [4:0] S_IDLE     = 5'd0;
    localparam logic [4:0] S_HDR      = 5'd1;
    localparam logic [4:0] S_SHIFT    = 5'd2;
    localparam logic [4:0] S_SKIP     = 5'd3;
    localparam logic [4:0] S_COMMIT   = 5'd4;
    localparam logic [4:0] S_RD_WAIT  = 5'd5;
    localparam logic [4:0] S_RD_SHIFT = 5'd6;

    typedef enum logic [4:0] {
        ST_IDLE     = S_IDLE,
        ST_HDR      = S_HDR,
        ST_SHIFT    = S_SHIFT,
        ST_SKIP     = S_SKIP,
        ST_COMMIT   = S_COMMIT,
        ST_RD_WAIT  = S_RD_WAIT,
        ST_RD_SHIFT = S_RD_SHIFT
    } slave_state_e;

endpackage

// File: rtl/slave_mem.sv
// Single-port word memory, synchronous write and registered read, kept free of reset
// so it can map onto block RAM. Read-during-write returns the old word.
module slave_mem #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_slave_serial_rx.sv
// Serial bus slave: deserialises address/data frames from the write master, decodes
// the slave id, writes or reads the local memory and streams read bytes back MSB first.
module bus_slave_serial_rx
    import bus_pkg::*;
#(
    parameter logic [ID_W-1:0] SLAVE_ID = SLAVE_ID_1,
    parameter int              MEM_AW   = 8,
    parameter int              RD_LAT   = 2,
    parameter int              TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_s,
    input  logic              addr_tx,
    input  logic              data_tx,
    input  logic              write_en_slave,
    output logic              slave_ready,
    output logic              rd_valid,
    output logic              rd_data,
    output logic              wr_strobe,
    output logic [DATA_W-1:0] last_wr_data
);

    localparam int PW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PAUSE_MAX = PW'(TIMEOUT);
    // The registered RAM read needs at least one wait cycle, even for RD_LAT==1.
    localparam int RD_WAIT_LEN = (RD_LAT > 1) ? RD_LAT - 1 : 1;
    localparam int WW = (RD_WAIT_LEN > 1) ? $clog2(RD_WAIT_LEN + 1) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'(RD_WAIT_LEN - 1);
    localparam logic [3:0] LAST_BIT   = 4'(ADDR_W - 1);
    localparam logic [3:0] DATA_FIRST = 4'(DATA_START_BIT);

    slave_state_e      state_q, state_d;
    logic              rw_q, rw_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]     pause_cnt_q, pause_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rd_sr_q, rd_sr_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [2:0]        sh_cnt_q, sh_cnt_d;
    logic [DATA_W-1:0] last_wr_q, last_wr_d;
    logic [3:0]        bit_idx;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign bit_idx = LAST_BIT - bit_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rw_q        <= 1'b0;
            bit_cnt_q   <= '0;
            pause_cnt_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rd_sr_q     <= '0;
            wait_cnt_q  <= '0;
            sh_cnt_q    <= '0;
            last_wr_q   <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            bit_cnt_q   <= bit_cnt_d;
            pause_cnt_q <= pause_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rd_sr_q     <= rd_sr_d;
            wait_cnt_q  <= wait_cnt_d;
            sh_cnt_q    <= sh_cnt_d;
            last_wr_q   <= last_wr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        bit_cnt_d   = bit_cnt_q;
        pause_cnt_d = pause_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rd_sr_d     = rd_sr_q;
        wait_cnt_d  = wait_cnt_q;
        sh_cnt_d    = sh_cnt_q;
        last_wr_d   = last_wr_q;
        mem_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_s) begin
                    rw_d    = write_en_slave;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                bit_cnt_d   = '0;
                pause_cnt_d = '0;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT, ST_SKIP: begin
                if (pause_cnt_q == PAUSE_MAX) begin
                    pause_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else if (!valid_s) begin
                    pause_cnt_d = pause_cnt_q + PW'(1);
                end else begin
                    pause_cnt_d = '0;
                    if (state_q == ST_SHIFT) begin
                        addr_d[bit_idx] = addr_tx;
                        if (bit_cnt_q >= DATA_FIRST && !rw_q) begin
                            data_d[bit_idx[2:0]] = data_tx;
                        end
                    end
                    if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    // Id is complete once bit 1 arrives; bit 0 already sits in addr_q[13].
                    if (state_q == ST_SHIFT && bit_cnt_q == 4'd1 &&
                        {addr_q[ADDR_W-1], addr_tx} != SLAVE_ID) begin
                        state_d = ST_SKIP;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        wait_cnt_d = WAIT_LOAD;
                        if (state_q == ST_SKIP) begin
                            state_d = ST_IDLE;
                        end else if (rw_q) begin
                            state_d = ST_RD_WAIT;
                        end else begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                mem_we    = 1'b1;
                last_wr_d = data_q;
                state_d   = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (wait_cnt_q == '0) begin
                    rd_sr_d  = mem_rdata;
                    sh_cnt_d = 3'd7;
                    state_d  = ST_RD_SHIFT;
                end else begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end
            end
            ST_RD_SHIFT: begin
                rd_sr_d = {rd_sr_q[DATA_W-2:0], 1'b0};
                if (sh_cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    sh_cnt_d = sh_cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Addressing from addr_d lets the RAM read the final address on the bit-13 edge.
    slave_mem #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_d[MEM_AW-1:0]),
        .wdata (data_q),
        .rdata (mem_rdata)
    );

    assign slave_ready  = (state_q == ST_IDLE) || (state_q == ST_HDR) ||
                          (state_q == ST_SHIFT) || (state_q == ST_SKIP);
    assign rd_valid     = (state_q == ST_RD_SHIFT);
    assign rd_data      = rd_valid & rd_sr_q[DATA_W-1];
    assign wr_strobe    = (state_q == ST_COMMIT);
    assign last_wr_data = last_wr_q;

endmodule

// File: tb/tb_bus_slave_serial_rx.sv
// Table-driven bench for bus_slave_serial_rx with a read-byte scoreboard.
module tb_bus_slave_serial_rx;

    localparam int TIMEOUT = 1023;
    localparam int RD_LAT  = 2;

    logic       clk, reset, valid_s, addr_tx, data_tx, write_en_slave;
    logic       slave_ready, rd_valid, rd_data, wr_strobe;
    logic [7:0] last_wr_data;

    bus_slave_serial_rx #(
        .SLAVE_ID (2'b01),
        .MEM_AW   (8),
        .RD_LAT   (RD_LAT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_s        (valid_s),
        .addr_tx        (addr_tx),
        .data_tx        (data_tx),
        .write_en_slave (write_en_slave),
        .slave_ready    (slave_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .wr_strobe      (wr_strobe),
        .last_wr_data   (last_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_WR, K_RD, K_SKIP, K_ABORT} kind_e;
    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
        logic        rw;
        int          pause_at;
        int          pause_len;
        kind_e       kind;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t       vecs[20];
    logic [7:0] sb_q[$];
    logic [7:0] exp_last;
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Read-byte monitor: collects each rd_valid burst and pops its expected byte.
    logic [7:0] rx_byte = '0;
    int         rx_run = 0;
    bit         rx_ready_bad = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rd_valid === 1'b1) begin
            rx_byte = {rx_byte[6:0], rd_data};
            rx_run++;
            if (slave_ready !== 1'b0) rx_ready_bad = 1'b1;
        end else if (rx_run != 0) begin
            check("rd_valid burst length", rx_run, 8);
            check("slave_ready low during read", {31'd0, rx_ready_bad}, 0);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected read byte: got %0h, expected none", rx_byte);
            end else begin
                check("rd byte", rx_byte, sb_q.pop_front());
            end
            rx_run = 0;
            rx_ready_bad = 1'b0;
        end
    end

    // Header cycle, HDR cycle, then 14 bits; optional pause after bit pause_at.
    task automatic send_frame(input logic [13:0] a, input logic [7:0] d, input logic rw,
                              input int pause_at, input int pause_len, input bit stop);
        @(negedge clk);
        valid_s = 1'b1; write_en_slave = rw; addr_tx = 1'b0; data_tx = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        for (int b = 0; b < 14; b++) begin
            @(negedge clk);
            valid_s = 1'b1;
            addr_tx = a[13-b];
            data_tx = (b >= 6) ? d[13-b] : 1'b0;
            @(posedge clk);
            if (b == pause_at) begin
                for (int p = 0; p < pause_len; p++) begin
                    @(negedge clk);
                    valid_s = 1'b0;
                    @(posedge clk);
                end
                if (stop) begin
                    @(negedge clk);
                    valid_s = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(slave_ready === 1'b1 && rd_valid === 1'b0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " back to idle"}, {30'd0, slave_ready, rd_valid}, 32'h2);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int i);
        vec_t  v;
        string tag;
        v = vecs[i];
        tag = $sformatf("v%0d", i);
        if (v.kind == K_RD) sb_q.push_back(v.exp_rd);
        send_frame(v.addr, v.data, v.rw, v.pause_at, v.pause_len, v.kind == K_ABORT);
        #1;
        if (v.kind == K_ABORT) begin
            check({tag, " abort wr_strobe"}, wr_strobe, 0);
            check({tag, " abort slave_ready"}, slave_ready, 1);
        end else begin
            check({tag, " wr_strobe after bit13"}, wr_strobe, v.kind == K_WR);
            check({tag, " slave_ready after bit13"}, slave_ready, v.kind == K_SKIP);
            check({tag, " rd_valid after bit13"}, rd_valid, 0);
            @(negedge clk);
            valid_s = 1'b0;
            @(posedge clk);
            #1;
            if (v.kind == K_WR) exp_last = v.data;
            check({tag, " wr_strobe one cycle"}, wr_strobe, 0);
            check({tag, " last_wr_data"}, last_wr_data, exp_last);
            check({tag, " rd_valid latency"}, rd_valid, v.kind == K_RD);
            check({tag, " slave_ready"}, slave_ready, v.kind != K_RD);
        end
        wait_idle(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{14'h1005, 8'hA5, 1'b0, -1, 0, K_WR, 8'h00};
        vecs[1]  = '{14'h1005, 8'h00, 1'b1, -1, 0, K_RD, 8'hA5};
        vecs[2]  = '{14'h2005, 8'h3C, 1'b0, -1, 0, K_SKIP, 8'h00};
        vecs[3]  = '{14'h1005, 8'hFF, 1'b1, -1, 0, K_RD, 8'hA5};
        vecs[4]  = '{14'h1010, 8'h77, 1'b0, 3, 5, K_WR, 8'h00};
        vecs[5]  = '{14'h1010, 8'h00, 1'b1, -1, 0, K_RD, 8'h77};
        vecs[6]  = '{14'h1010, 8'h55, 1'b0, 9, TIMEOUT + 3, K_ABORT, 8'h00};
        vecs[7]  = '{14'h1011, 8'h42, 1'b0, -1, 0, K_WR, 8'h00};
        vecs[8]  = '{14'h1010, 8'h00, 1'b1, -1, 0, K_RD, 8'h77};
        vecs[9]  = '{14'h1011, 8'h00, 1'b1, -1, 0, K_RD, 8'h42};
        vecs[10] = '{14'h1012, 8'h99, 1'b0, 9, TIMEOUT - 1, K_WR, 8'h00};
        vecs[11] = '{14'h1012, 8'h00, 1'b1, -1, 0, K_RD, 8'h99};
        vecs[12] = '{14'h3105, 8'hE1, 1'b0, 5, 4, K_SKIP, 8'h00};
        vecs[13] = '{14'h1105, 8'hC3, 1'b0, -1, 0, K_WR, 8'h00};
        vecs[14] = '{14'h0005, 8'h00, 1'b1, -1, 0, K_SKIP, 8'h00};
        vecs[15] = '{14'h1F05, 8'h00, 1'b1, -1, 0, K_RD, 8'hC3};
        vecs[16] = '{14'h1020, 8'h11, 1'b0, -1, 0, K_WR, 8'h00};
        vecs[17] = '{14'h1020, 8'h00, 1'b1, -1, 0, K_RD, 8'h11};
        vecs[18] = '{14'h1020, 8'h5A, 1'b0, -1, 0, K_WR, 8'h00};
        vecs[19] = '{14'h1020, 8'h00, 1'b1, -1, 0, K_RD, 8'h5A};

        reset = 1'b0; valid_s = 1'b0; addr_tx = 1'b0; data_tx = 1'b0; write_en_slave = 1'b0;
        exp_last = 8'h00;
        #3;
        check("reset slave_ready", slave_ready, 1);
        check("reset rd_valid", rd_valid, 0);
        check("reset wr_strobe", wr_strobe, 0);
        check("reset last_wr_data", last_wr_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) run_vec(i);

        // Reset asserted right after bit 7 of a write: outputs clear without a clock edge.
        send_frame(14'h1020, 8'hEE, 1'b0, 7, 0, 1'b1);
        reset = 1'b0;
        #1;
        check("midframe reset slave_ready", slave_ready, 1);
        check("midframe reset wr_strobe", wr_strobe, 0);
        check("midframe reset rd_valid", rd_valid, 0);
        check("midframe reset rd_data", rd_data, 0);
        check("midframe reset last_wr_data", last_wr_data, 0);
        exp_last = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 17; i < 20; i++) run_vec(i);

        repeat (4) @(negedge clk);
        check("scoreboard drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
